// File: rtl/register_file.sv
`default_nettype none
// ============================================================================
//  Module   : register_file
//  Purpose  : General-purpose register file for the single-cycle CPU. It has
//             two combinational read ports for the ALU operands, one
//             synchronous write port for the write-back result, and a
//             non-bypassed debug read port. Register 0 is hardwired to zero.
//             An optional write-to-read bypass makes a same-cycle
//             read-after-write return the incoming write data.
//  Ports    : clk      - clock; all state updates on the rising edge
//             reset    - asynchronous, active-high; clears every register
//             rs_addr  - read port A index   -> rs_data
//             rt_addr  - read port B index   -> rt_data
//             we       - write enable (RegWrite)
//             rd_addr  - write index
//             rd_data  - write-back value
//             dbg_addr - debug read index    -> dbg_data (never bypassed)
//  Revision : 1.0 - initial release
// ============================================================================
module register_file #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter bit BYPASS = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    input  logic              we,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    localparam int c_depth = 2 ** ADDR_W;

    // Flattened view of the file; entry 0 is a constant zero, not storage.
    logic [DATA_W-1:0] w_file [0:c_depth-1];

    logic w_addr_known;
    logic w_wr_en;
    logic w_rs_hit;
    logic w_rt_hit;

    // An unknown write address (X/Z in simulation) reduces to X under XOR;
    // such a write is dropped so it cannot scribble over the file.
    assign w_addr_known = ((^rd_addr) !== 1'bx);

    // Writes to index 0 are ignored, which keeps register 0 at zero.
    assign w_wr_en = we && (rd_addr != '0) && w_addr_known;

    assign w_file[0] = '0;

    generate
        for (genvar i = 1; i < c_depth; i++) begin : g_reg
            logic [DATA_W-1:0] r_q;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_q <= '0;
                end else if (w_wr_en && (rd_addr == ADDR_W'(i))) begin
                    r_q <= rd_data;
                end
            end

            assign w_file[i] = r_q;
        end
    endgenerate

    // w_wr_en already excludes index 0, so a bypass hit can never override
    // the zero rule; the explicit zero test below keeps that obvious.
    assign w_rs_hit = BYPASS && w_wr_en && (rs_addr == rd_addr);
    assign w_rt_hit = BYPASS && w_wr_en && (rt_addr == rd_addr);

    always_comb begin
        rs_data = w_file[rs_addr];
        if (rs_addr == '0) begin
            rs_data = '0;
        end else if (w_rs_hit) begin
            rs_data = rd_data;
        end
    end

    always_comb begin
        rt_data = w_file[rt_addr];
        if (rt_addr == '0) begin
            rt_data = '0;
        end else if (w_rt_hit) begin
            rt_data = rd_data;
        end
    end

    assign dbg_data = (dbg_addr == '0) ? '0 : w_file[dbg_addr];

endmodule
`default_nettype wire

// File: tb/tb_register_file.sv
`default_nettype none
// ============================================================================
//  Module   : tb_register_file
//  Purpose  : Directed self-checking bench for register_file. Two instances
//             share all inputs: one built with the bypass, one without.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_register_file;

    localparam int c_data_w = 32;
    localparam int c_addr_w = 5;

    logic                clk;
    logic                reset;
    logic [c_addr_w-1:0] rs_addr;
    logic [c_addr_w-1:0] rt_addr;
    logic                we;
    logic [c_addr_w-1:0] rd_addr;
    logic [c_data_w-1:0] rd_data;
    logic [c_addr_w-1:0] dbg_addr;

    logic [c_data_w-1:0] w_rs_b, w_rt_b, w_dbg_b;   // BYPASS=1 instance
    logic [c_data_w-1:0] w_rs_n, w_rt_n, w_dbg_n;   // BYPASS=0 instance

    int checks;
    int failures;

    register_file #(.DATA_W(c_data_w), .ADDR_W(c_addr_w), .BYPASS(1'b1)) u_dut_byp (
        .clk      (clk),
        .reset    (reset),
        .rs_addr  (rs_addr),
        .rt_addr  (rt_addr),
        .rs_data  (w_rs_b),
        .rt_data  (w_rt_b),
        .we       (we),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .dbg_addr (dbg_addr),
        .dbg_data (w_dbg_b)
    );

    register_file #(.DATA_W(c_data_w), .ADDR_W(c_addr_w), .BYPASS(1'b0)) u_dut_nobyp (
        .clk      (clk),
        .reset    (reset),
        .rs_addr  (rs_addr),
        .rt_addr  (rt_addr),
        .rs_data  (w_rs_n),
        .rt_data  (w_rt_n),
        .we       (we),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .dbg_addr (dbg_addr),
        .dbg_data (w_dbg_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [c_data_w-1:0] got,
                         input logic [c_data_w-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Drive a write in the low phase, take it on the next rising edge.
    task automatic do_write(input logic [c_addr_w-1:0] a, input logic [c_data_w-1:0] d);
        @(negedge clk);
        we      = 1'b1;
        rd_addr = a;
        rd_data = d;
        @(posedge clk);
        #1;
        we = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        we       = 1'b0;
        rs_addr  = '0;
        rt_addr  = '0;
        rd_addr  = '0;
        rd_data  = '0;
        dbg_addr = '0;

        // ---------------- reset state ----------------
        #2;
        dbg_addr = 5'd1;
        rs_addr  = 5'd31;
        #1;
        check("reset_dbg1", w_dbg_b, 32'h0);
        check("reset_rs31", w_rs_b, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        // ---------------- basic write/read ----------------
        do_write(5'd5, 32'hDEADBEEF);
        rs_addr = 5'd5; rt_addr = 5'd5; dbg_addr = 5'd6;
        #1;
        check("basic_rs5", w_rs_b, 32'hDEADBEEF);
        check("basic_rt5", w_rt_b, 32'hDEADBEEF);
        check("basic_rs5_nobyp", w_rs_n, 32'hDEADBEEF);
        check("basic_dbg6", w_dbg_b, 32'h0);
        dbg_addr = 5'd5;
        #1;
        check("basic_dbg5", w_dbg_b, 32'hDEADBEEF);

        // ---------------- zero register ----------------
        @(negedge clk);
        we = 1'b1; rd_addr = 5'd0; rd_data = 32'hFFFFFFFF;
        rs_addr = 5'd0; rt_addr = 5'd0;
        #1;
        check("zero_rs_same_cycle_byp", w_rs_b, 32'h0);
        check("zero_rt_same_cycle_byp", w_rt_b, 32'h0);
        @(posedge clk);
        #1;
        we = 1'b0;
        dbg_addr = 5'd0;
        #1;
        check("zero_rs_after", w_rs_b, 32'h0);
        check("zero_dbg_after", w_dbg_b, 32'h0);

        // ---------------- bypass ----------------
        do_write(5'd7, 32'h11);
        @(negedge clk);
        we = 1'b1; rd_addr = 5'd7; rd_data = 32'h22;
        rs_addr = 5'd7; rt_addr = 5'd7; dbg_addr = 5'd7;
        #1;
        check("byp_rs7", w_rs_b, 32'h22);
        check("byp_rt7", w_rt_b, 32'h22);
        check("nobyp_rs7", w_rs_n, 32'h11);
        check("nobyp_rt7", w_rt_n, 32'h11);
        check("byp_dbg7_not_bypassed", w_dbg_b, 32'h11);
        @(posedge clk);
        #1;
        we = 1'b0;
        #1;
        check("byp_rs7_after", w_rs_b, 32'h22);
        check("nobyp_rs7_after", w_rs_n, 32'h22);

        // Read of a different register while writing: unaffected.
        @(negedge clk);
        we = 1'b1; rd_addr = 5'd8; rd_data = 32'h55;
        rs_addr = 5'd7; rt_addr = 5'd5;
        #1;
        check("diff_rs7", w_rs_b, 32'h22);
        check("diff_rt5", w_rt_b, 32'hDEADBEEF);
        @(posedge clk);
        #1;
        we = 1'b0;
        rs_addr = 5'd8;
        #1;
        check("diff_r8_written", w_rs_b, 32'h55);

        // ---------------- write disable ----------------
        @(negedge clk);
        we = 1'b0; rd_addr = 5'd3; rd_data = 32'hAB;
        @(posedge clk);
        #1;
        dbg_addr = 5'd3;
        #1;
        check("wdis_r3", w_dbg_b, 32'h0);

        // ---------------- reset racing a write ----------------
        @(negedge clk);
        we = 1'b1; rd_addr = 5'd3; rd_data = 32'hAB;
        reset = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        reset = 1'b0;
        we = 1'b0;
        #1;
        check("race_r3", w_dbg_b, 32'h0);

        // ---------------- reset between edges clears everything ----------
        do_write(5'd9, 32'h99);
        do_write(5'd31, 32'h31313131);
        #2;
        reset = 1'b1;
        #1;
        for (int i = 1; i < 32; i++) begin
            dbg_addr = i[4:0];
            #0.1;
            check($sformatf("async_rst_dbg%0d", i), w_dbg_b, 32'h0);
        end
        rs_addr = 5'd9; rt_addr = 5'd31;
        #0.1;
        check("async_rst_rs9", w_rs_b, 32'h0);
        check("async_rst_rt31", w_rt_b, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        // First write after release is taken on the first edge.
        do_write(5'd4, 32'h44);
        dbg_addr = 5'd4;
        #1;
        check("post_rst_first_write", w_dbg_b, 32'h44);

        // ---------------- full sweep ----------------
        for (int i = 1; i < 32; i++) begin
            do_write(i[4:0], i * 32'h01010101);
        end
        for (int i = 0; i < 32; i++) begin
            logic [c_data_w-1:0] exp;
            exp = (i == 0) ? 32'h0 : i * 32'h01010101;
            rs_addr  = i[4:0];
            rt_addr  = 5'(31 - i);
            dbg_addr = i[4:0];
            #1;
            check($sformatf("sweep_rs%0d", i), w_rs_b, exp);
            check($sformatf("sweep_dbg%0d", i), w_dbg_b, exp);
            check($sformatf("sweep_rs%0d_nobyp", i), w_rs_n, exp);
            check($sformatf("sweep_rt%0d", 31 - i), w_rt_b,
                  (i == 31) ? 32'h0 : (31 - i) * 32'h01010101);
        end
        rs_addr = 5'd12; rt_addr = 5'd12;
        #1;
        check("same_addr_rs", w_rs_b, 32'h0C0C0C0C);
        check("same_addr_rt", w_rt_b, 32'h0C0C0C0C);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
